// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing, colour constants and coordinate type
// for the pong VGA scanout.
//   H_/V_ localparams : active, porch and sync widths plus derived totals
//   colour constants  : BLACK, WHITE and the eight-entry colour-bar palette
//   coord_t           : 10-bit pixel/line coordinate
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int BAR_WIDTH = 80;

    typedef logic [9:0] coord_t;

    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_color(input logic [2:0] bar);
        logic [23:0] c;
        c = (bar == 3'd0) ? WHITE   :
            (bar == 3'd1) ? YELLOW  :
            (bar == 3'd2) ? CYAN    :
            (bar == 3'd3) ? GREEN   :
            (bar == 3'd4) ? MAGENTA :
            (bar == 3'd5) ? RED     :
            (bar == 3'd6) ? BLUE    : BLACK;
        return c;
    endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// vga_pix_ce: divides the system clock into a one-cycle pixel enable.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   o_pix_ce : high in the cycle where the divider count reaches CLK_DIV-1
//              (constantly high when CLK_DIV = 1)
module vga_pix_ce #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_pix_ce
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] r_div_cnt;

    assign o_pix_ce = (r_div_cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_div_cnt <= '0;
        else
            r_div_cnt <= o_pix_ce ? '0 : r_div_cnt + 1'b1;
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator with registered colour/sync
// output and a once-per-frame tick for the pong game logic.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   i_test_mode     : colour-bar override (only with VGA_SCANOUT_TEST_PATTERN_EN)
//   i_color         : renderer colour {R,G,B} for (o_x,o_y), same cycle
//   o_x, o_y        : current horizontal / vertical counts
//   o_vga_r/g/b     : registered pixel colour, zero during blanking
//   o_vga_hs/vs     : registered syncs, asserted level SYNC_ACTIVE
//   o_vga_de        : registered data-enable
//   o_frame_tick    : one-clk pulse entering vertical blanking
// Define VGA_SCANOUT_TEST_PATTERN_EN to add i_test_mode and the colour bars.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   HA          = H_ACTIVE,
    parameter int   HF          = H_FP,
    parameter int   HS          = H_SYNC,
    parameter int   HB          = H_BP,
    parameter int   VA          = V_ACTIVE,
    parameter int   VF          = V_FP,
    parameter int   VS          = V_SYNC,
    parameter int   VB          = V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic        i_test_mode,
`endif
    input  logic [23:0] i_color,
    output coord_t      o_x,
    output coord_t      o_y,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_de,
    output logic        o_frame_tick
);

    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        w_pix_ce;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    logic        w_hs0;
    logic        w_vs0;
    logic [23:0] w_color;
    coord_t      r_h;
    coord_t      r_v;
    logic [23:0] r_rgb;
    logic        r_de;
    logic        r_hs;
    logic        r_vs;

    vga_pix_ce #(.CLK_DIV(CLK_DIV)) u_pix_ce (
        .clk      (clk),
        .rst_n    (rst_n),
        .o_pix_ce (w_pix_ce)
    );

    assign w_h_last = (r_h == coord_t'(HT - 1));
    assign w_v_last = (r_v == coord_t'(VT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_ce) begin
            r_h <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last)
                r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
    end

    always_comb begin
        w_active = (r_h < coord_t'(HA)) && (r_v < coord_t'(VA));
        w_hs0    = (r_h >= coord_t'(HA + HF)) && (r_h < coord_t'(HA + HF + HS));
        w_vs0    = (r_v >= coord_t'(VA + VF)) && (r_v < coord_t'(VA + VF + VS));
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        w_color  = i_test_mode ? bar_color(3'(r_h / coord_t'(BAR_WIDTH))) : i_color;
`else
        w_color  = i_color;
`endif
    end

    // Colour and syncs share one register stage so the DAC sees them aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= BLACK;
            r_de  <= 1'b0;
            r_hs  <= ~SYNC_ACTIVE;
            r_vs  <= ~SYNC_ACTIVE;
        end else if (w_pix_ce) begin
            r_rgb <= w_active ? w_color : BLACK;
            r_de  <= w_active;
            r_hs  <= w_hs0 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs  <= w_vs0 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign o_x          = r_h;
    assign o_y          = r_v;
    assign o_vga_r      = r_rgb[23:16];
    assign o_vga_g      = r_rgb[15:8];
    assign o_vga_b      = r_rgb[7:0];
    assign o_vga_de     = r_de;
    assign o_vga_hs     = r_hs;
    assign o_vga_vs     = r_vs;
    // Fires on the pixel step from the last visible line into vertical blanking
    assign o_frame_tick = w_pix_ce && w_h_last && (r_v == coord_t'(VA - 1));

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout using a reduced raster
// so several frames fit in a short run; expectations come from a
// pixel-index model of the scan.
module tb_vga_scanout;

    localparam int CD = 2;
    localparam int HA = 104, HF = 4, HS = 8, HB = 6;
    localparam int VA = 52, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        tick;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] key = 24'h00005A;
    logic        white = 1'b0;
    logic [23:0] in_color;
    logic [9:0]  o_x, o_y;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_hs, o_vs, o_de, o_tick;
    obs_t        got;
    int          c;
    int          n_pass = 0;
    int          n_total = 0;

    vga_scanout #(
        .CLK_DIV(CD), .SYNC_ACTIVE(1'b0),
        .HA(HA), .HF(HF), .HS(HS), .HB(HB),
        .VA(VA), .VF(VF), .VS(VS), .VB(VB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_color      (in_color),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_vga_r      (o_r),
        .o_vga_g      (o_g),
        .o_vga_b      (o_b),
        .o_vga_hs     (o_hs),
        .o_vga_vs     (o_vs),
        .o_vga_de     (o_de),
        .o_frame_tick (o_tick)
    );

    always #5 clk = ~clk;

    // Renderer stand-in: colour is a keyed function of the presented coordinate
    assign in_color = white ? 24'hFFFFFF : {o_x[7:0] ^ key[23:16], o_y[7:0] ^ key[15:8], key[7:0]};
    assign got = {o_x, o_y, o_r, o_g, o_b, o_de, o_hs, o_vs, o_tick};

    // Clock edges seen since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            c <= 0;
        else
            c <= c + 1;
    end

    function automatic logic [23:0] col(input int h, input int v);
        return white ? 24'hFFFFFF : {8'(h) ^ key[23:16], 8'(v) ^ key[15:8], key[7:0]};
    endfunction

    // Expected outputs after cc clock edges: pixel p is presented, pixel p-1 is on the output
    function automatic obs_t model(input int cc);
        obs_t o;
        int   p, q, ph, pv;
        p      = cc / CD;
        o.x    = 10'(p % HT);
        o.y    = 10'((p / HT) % VT);
        o.tick = (cc % CD == CD - 1) && (p % HT == HT - 1) && ((p / HT) % VT == VA - 1);
        if (p == 0) begin
            o.rgb = '0;
            o.de  = 1'b0;
            o.hs  = 1'b1;
            o.vs  = 1'b1;
        end else begin
            q     = p - 1;
            ph    = q % HT;
            pv    = (q / HT) % VT;
            o.de  = (ph < HA) && (pv < VA);
            o.rgb = o.de ? col(ph, pv) : 24'h0;
            o.hs  = !((ph >= HA + HF) && (ph < HA + HF + HS));
            o.vs  = !((pv >= VA + VF) && (pv < VA + VF + VS));
        end
        return o;
    endfunction

    task automatic restart();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        key = 24'h00005A;
        white = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (o_x !== 10'd0) $display("FAIL reset_x: got %0d expected 0", o_x); else n_pass++;
        n_total++; if (o_y !== 10'd0) $display("FAIL reset_y: got %0d expected 0", o_y); else n_pass++;
        n_total++; if ({o_r, o_g, o_b} !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", {o_r, o_g, o_b}); else n_pass++;
        n_total++; if (o_de !== 1'b0) $display("FAIL reset_de: got %b expected 0", o_de); else n_pass++;
        n_total++; if (o_hs !== 1'b1) $display("FAIL reset_hs: got %b expected 1", o_hs); else n_pass++;
        n_total++; if (o_vs !== 1'b1) $display("FAIL reset_vs: got %b expected 1", o_vs); else n_pass++;
        n_total++; if (o_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", o_tick); else n_pass++;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (o_x !== 10'(i / CD)) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL x_increment: %0d of 8 samples wrong, last x %0d expected %0d", bad, o_x, 8 / CD); else n_pass++;
    endtask

    task automatic test_frame_timing();
        int   bad = 0, nf = 0, nt = 0, run = 0, max_w = 0;
        int   hs_fall[2] = '{-1, -1};
        int   hs_rise = -1, vs_fall = -1, vs_rise = -1;
        int   tk[2] = '{-1, -1};
        logic p_hs = 1'b1, p_vs = 1'b1, p_tk = 1'b0;
        obs_t e, first_got, first_exp;
        key = 24'($urandom);
        white = 1'b0;
        restart();
        for (int i = 0; i < 27200; i++) begin
            @(negedge clk);
            e = model(c);
            if (got !== e) begin
                if (bad == 0) begin first_got = got; first_exp = e; end
                bad++;
            end
            if (p_hs && !got.hs) begin if (nf < 2) hs_fall[nf] = c; nf++; end
            if (!p_hs && got.hs && hs_rise < 0) hs_rise = c;
            if (p_vs && !got.vs && vs_fall < 0) vs_fall = c;
            if (!p_vs && got.vs && vs_rise < 0) vs_rise = c;
            if (got.tick) begin
                if (!p_tk) begin if (nt < 2) tk[nt] = c; nt++; run = 1; end
                else run++;
                if (run > max_w) max_w = run;
            end
            p_hs = got.hs; p_vs = got.vs; p_tk = got.tick;
        end
        n_total++; if (bad !== 0) $display("FAIL scan_model: %0d bad samples, first got %h expected %h", bad, first_got, first_exp); else n_pass++;
        n_total++; if (hs_fall[0] !== (HA + HF + 1) * CD) $display("FAIL hs_start: got %0d expected %0d", hs_fall[0], (HA + HF + 1) * CD); else n_pass++;
        n_total++; if (hs_rise - hs_fall[0] !== HS * CD) $display("FAIL hs_width: got %0d expected %0d", hs_rise - hs_fall[0], HS * CD); else n_pass++;
        n_total++; if (hs_fall[1] - hs_fall[0] !== HT * CD) $display("FAIL line_period: got %0d expected %0d", hs_fall[1] - hs_fall[0], HT * CD); else n_pass++;
        n_total++; if (vs_fall !== ((VA + VF) * HT + 1) * CD) $display("FAIL vs_start: got %0d expected %0d", vs_fall, ((VA + VF) * HT + 1) * CD); else n_pass++;
        n_total++; if (vs_rise - vs_fall !== VS * HT * CD) $display("FAIL vs_width: got %0d expected %0d", vs_rise - vs_fall, VS * HT * CD); else n_pass++;
        n_total++; if (tk[0] !== VA * HT * CD - 1) $display("FAIL first_tick: got %0d expected %0d", tk[0], VA * HT * CD - 1); else n_pass++;
        n_total++; if (tk[1] - tk[0] !== HT * VT * CD) $display("FAIL tick_period: got %0d expected %0d", tk[1] - tk[0], HT * VT * CD); else n_pass++;
        n_total++; if (max_w !== 1) $display("FAIL tick_width: got %0d expected 1", max_w); else n_pass++;
    endtask

    task automatic test_alignment();
        logic found = 1'b0;
        key = 24'h00005A;
        white = 1'b0;
        restart();
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (o_x == 10'd101 && o_y == 10'd50) found = 1'b1;
        end
        n_total++; if (found !== 1'b1) $display("FAIL align_reach: got found=%b expected 1 (timeout)", found); else n_pass++;
        n_total++; if ({o_r, o_g, o_b} !== 24'h64325A) $display("FAIL align_rgb: got %h expected 64325a", {o_r, o_g, o_b}); else n_pass++;
        n_total++; if (o_de !== 1'b1) $display("FAIL align_de: got %b expected 1", o_de); else n_pass++;
        @(negedge clk);
        n_total++; if ({o_x, o_r, o_g, o_b} !== {10'd101, 24'h64325A}) $display("FAIL align_hold: got x=%0d rgb=%h expected x=101 rgb=64325a", o_x, {o_r, o_g, o_b}); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic found = 1'b0;
        int   bad = 0, tick_at = -1;
        obs_t e, first_got, first_exp;
        white = 1'b1;
        restart();
        for (int i = 0; i < 10000 && !found; i++) begin
            @(negedge clk);
            if (o_x == 10'd100 && o_y == 10'd30) found = 1'b1;
        end
        n_total++; if (found !== 1'b1) $display("FAIL midreset_reach: got found=%b expected 1 (timeout)", found); else n_pass++;
        n_total++; if ({o_r, o_g, o_b, o_de} !== {24'hFFFFFF, 1'b1}) $display("FAIL midreset_pre: got rgb=%h de=%b expected ffffff 1", {o_r, o_g, o_b}, o_de); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if ({o_x, o_y} !== 20'd0) $display("FAIL midreset_xy: got %0d,%0d expected 0,0", o_x, o_y); else n_pass++;
        n_total++; if ({o_r, o_g, o_b, o_de, o_hs, o_vs, o_tick} !== {24'h0, 4'b0110}) $display("FAIL midreset_out: got rgb=%h de=%b hs=%b vs=%b tick=%b expected 000000 0 1 1 0", {o_r, o_g, o_b}, o_de, o_hs, o_vs, o_tick); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < VA * HT * CD + 100 && tick_at < 0; i++) begin
            @(negedge clk);
            e = model(c);
            if (got !== e) begin
                if (bad == 0) begin first_got = got; first_exp = e; end
                bad++;
            end
            if (got.tick) tick_at = c;
        end
        n_total++; if (bad !== 0) $display("FAIL blank_model: %0d bad samples, first got %h expected %h", bad, first_got, first_exp); else n_pass++;
        n_total++; if (tick_at !== VA * HT * CD - 1) $display("FAIL midreset_tick: got %0d expected %0d", tick_at, VA * HT * CD - 1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_alignment();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
